// File: rtl/eth_tx_fcs_ctrl.sv
// Nibble-wide Ethernet TX frame sequencer: forwards the frame, zero-pads it to the minimum
// length, appends the FCS from a 4-bit-per-cycle CRC-32 engine, then holds the inter-frame gap.

module crc32_4bit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        data_valid,
    input  logic [3:0]  data_in,
    output logic [31:0] crc_out
);
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic [31:0] crc_q, crc_d;

    // MSB-first register fed in wire order (bit0 first): crc_out[31] is the first FCS bit sent.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '1;
        end else if (data_valid) begin
            for (int i = 0; i < 4; i++) begin
                crc_d = {crc_d[30:0], 1'b0} ^ ({32{crc_d[31] ^ data_in[i]}} & POLY);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) crc_q <= '1;
        else          crc_q <= crc_d;
    end

    assign crc_out = ~crc_q;
endmodule

module eth_tx_fcs_ctrl #(
    parameter int unsigned MIN_NIBBLES = 120,
    parameter int unsigned IFG_NIBBLES = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_FCS, S_IFG} state_e;

    localparam logic [15:0] MIN_CNT  = 16'(MIN_NIBBLES);
    localparam logic [15:0] IFG_LAST = 16'((IFG_NIBBLES == 0) ? 0 : IFG_NIBBLES - 1);

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] nib_cnt_q, nib_cnt_d;
    logic [2:0]  fcs_idx_q, fcs_idx_d;
    logic [15:0] ifg_cnt_q, ifg_cnt_d;

    logic        slot_free;
    logic        crc_clr, crc_valid;
    logic [3:0]  crc_din;
    logic [31:0] crc_val, crc_sh;
    logic [15:0] nib_inc;
    logic [3:0]  fcs_nib;

    crc32_4bit u_crc (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (crc_clr),
        .data_valid (crc_valid),
        .data_in    (crc_din),
        .crc_out    (crc_val)
    );

    assign slot_free = !out_valid_q || out_ready;
    assign crc_clr   = (state_q == S_IDLE) || (state_q == S_IFG);
    assign nib_inc   = (nib_cnt_q == 16'hFFFF) ? nib_cnt_q : nib_cnt_q + 16'd1;
    // FCS nibble k takes c[31-4k] as its bit0, i.e. the top nibble of c << 4k, bit-reversed.
    assign crc_sh    = crc_val << {fcs_idx_q, 2'b00};
    assign fcs_nib   = {crc_sh[28], crc_sh[29], crc_sh[30], crc_sh[31]};

    // NOTE: every signal gets a default at the top of the block, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        nib_cnt_d    = nib_cnt_q;
        fcs_idx_d    = fcs_idx_q;
        ifg_cnt_d    = ifg_cnt_q;
        frame_done_d = 1'b0;
        crc_valid    = 1'b0;
        crc_din      = 4'h0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                nib_cnt_d = '0;
                fcs_idx_d = '0;
                ifg_cnt_d = '0;
                if (in_valid) state_d = S_DATA;
            end
            S_DATA: begin
                if (in_valid && slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_last_d  = 1'b0;
                    crc_valid   = 1'b1;
                    crc_din     = in_data;
                    nib_cnt_d   = nib_inc;
                    if (in_last) state_d = (nib_inc < MIN_CNT) ? S_PAD : S_FCS;
                end
            end
            S_PAD: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 4'h0;
                    out_last_d  = 1'b0;
                    crc_valid   = 1'b1;
                    nib_cnt_d   = nib_inc;
                    if (nib_inc >= MIN_CNT) state_d = S_FCS;
                end
            end
            S_FCS: begin
                // Once the final nibble is in the slot, nothing more loads until it is taken.
                if (out_last_q) begin
                    if (out_ready) begin
                        state_d      = S_IFG;
                        frame_done_d = 1'b1;
                        ifg_cnt_d    = '0;
                    end
                end else if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = fcs_nib;
                    out_last_d  = (fcs_idx_q == 3'd7);
                    fcs_idx_d   = fcs_idx_q + 3'd1;
                end
            end
            S_IFG: begin
                if (ifg_cnt_q >= IFG_LAST) state_d = S_IDLE;
                else                       ifg_cnt_d = ifg_cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge values computed above.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= 4'h0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            nib_cnt_q    <= '0;
            fcs_idx_q    <= '0;
            ifg_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            nib_cnt_q    <= nib_cnt_d;
            fcs_idx_q    <= fcs_idx_d;
            ifg_cnt_q    <= ifg_cnt_d;
        end
    end

    assign in_ready   = (state_q == S_DATA) && slot_free;
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Directed bench for eth_tx_fcs_ctrl: one instance with padding disabled, one with defaults,
// sharing stimulus; sel picks which one is driven and observed.

module tb_eth_tx_fcs_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, sel;
    logic       in_valid, in_last, out_ready;
    logic [3:0] in_data;

    logic       in_valid_0, in_ready_0, out_valid_0, out_last_0, busy_0, frame_done_0;
    logic       in_valid_1, in_ready_1, out_valid_1, out_last_1, busy_1, frame_done_1;
    logic [3:0] out_data_0, out_data_1;

    logic       in_ready_o, out_valid_o, out_last_o, busy_o, frame_done_o;
    logic [3:0] out_data_o;

    assign in_valid_0 = in_valid & ~sel;
    assign in_valid_1 = in_valid & sel;

    eth_tx_fcs_ctrl #(.MIN_NIBBLES(0), .IFG_NIBBLES(24)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_0), .in_ready(in_ready_0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_0), .out_ready(out_ready), .out_data(out_data_0),
        .out_last(out_last_0), .busy(busy_0), .frame_done(frame_done_0)
    );

    eth_tx_fcs_ctrl u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1),
        .out_last(out_last_1), .busy(busy_1), .frame_done(frame_done_1)
    );

    assign in_ready_o   = sel ? in_ready_1   : in_ready_0;
    assign out_valid_o  = sel ? out_valid_1  : out_valid_0;
    assign out_data_o   = sel ? out_data_1   : out_data_0;
    assign out_last_o   = sel ? out_last_1   : out_last_0;
    assign busy_o       = sel ? busy_1       : busy_0;
    assign frame_done_o = sel ? frame_done_1 : frame_done_0;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] tx_q[$];
    bit         tx_l[$];
    logic [3:0] rx_q[$];
    bit         rxl_q[$];
    logic [3:0] exp_q[$];
    bit         expl_q[$];
    int         gap_runs[$];
    int         stall_seen, stall_bad, first_acc, first_ov, cyc_g;

    // Reference CRC in reflected form, bit-serial over the nibble stream in wire order.
    function automatic logic [31:0] sw_crc(input logic [3:0] nibs[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (nibs[i]) begin
            for (int b = 0; b < 4; b++) begin
                if (c[0] ^ nibs[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                   c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic push_bytes(input string s);
        logic [7:0] b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            tx_q.push_back(b[3:0]); tx_l.push_back(1'b0);
            tx_q.push_back(b[7:4]); tx_l.push_back(i == s.len() - 1);
        end
    endtask

    task automatic add_expected(input int min_nib, input int start, input int len);
        logic [3:0]  fr[$];
        logic [31:0] fcs;
        for (int i = 0; i < len; i++) fr.push_back(tx_q[start + i]);
        while (fr.size() < min_nib) fr.push_back(4'h0);
        fcs = sw_crc(fr);
        foreach (fr[i]) begin
            exp_q.push_back(fr[i]); expl_q.push_back(1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(fcs[4*k +: 4]); expl_q.push_back(k == 7);
        end
    endtask

    function automatic int first_diff();
        int n = (rx_q.size() > exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= rx_q.size() || i >= exp_q.size()) return i;
            if (rx_q[i] !== exp_q[i] || rxl_q[i] !== expl_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic report_stream(input string name, input int d);
        logic [3:0] g, w;
        bit gl, wl;
        g  = (d < rx_q.size())  ? rx_q[d]   : 4'hx;
        gl = (d < rxl_q.size()) ? rxl_q[d]  : 1'b0;
        w  = (d < exp_q.size()) ? exp_q[d]  : 4'hx;
        wl = (d < expl_q.size()) ? expl_q[d] : 1'b0;
        $display("FAIL %s: nibble %0d got %h last=%b (len %0d), required %h last=%b (len %0d)",
                 name, d, g, gl, rx_q.size(), w, wl, exp_q.size());
    endtask

    // Drives tx_q as a valid/ready stream and collects the output until n_frames
    // frame_done pulses are seen or the cycle budget runs out.
    task automatic run_stream(input bit bp, input bit gaps, input int n_frames,
                              input int max_cycles, output bit timed_out);
        int idx = 0, done_cnt = 0, cyc = 0, gap_run = 0;
        bit acc = 0, prev_stall = 0, gap_track = 0;
        logic [3:0] prev_data = 4'h0;
        timed_out = 1'b0;
        rx_q.delete(); rxl_q.delete(); gap_runs.delete();
        stall_seen = 0; stall_bad = 0; first_acc = -1; first_ov = -1;
        in_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc_g++;
            if (acc) begin idx++; in_valid = 1'b0; acc = 0; end
            if (frame_done_o) done_cnt++;
            if (done_cnt == n_frames) break;
            if (cyc >= max_cycles) begin timed_out = 1'b1; break; end
            cyc++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx < tx_q.size()) begin
                if (!in_valid) in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data = tx_q[idx];
                in_last = tx_l[idx];
            end else begin
                in_valid = 1'b0; in_last = 1'b0; in_data = 4'h0;
            end
            #1;
            if (prev_stall && (out_valid_o !== 1'b1 || out_data_o !== prev_data)) stall_bad++;
            prev_stall = out_valid_o && !out_ready;
            if (prev_stall) begin prev_data = out_data_o; stall_seen++; end
            if (gap_track) begin
                if (in_ready_o) begin gap_runs.push_back(gap_run); gap_track = 0; end
                else gap_run++;
            end
            if (out_valid_o && first_ov < 0) first_ov = cyc_g;
            if (out_valid_o && out_ready) begin
                rx_q.push_back(out_data_o); rxl_q.push_back(out_last_o);
                if (out_last_o) begin gap_track = 1; gap_run = 0; end
            end
            if (in_valid && in_ready_o) begin
                acc = 1;
                if (first_acc < 0) first_acc = cyc_g;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic load_frame1_expected();
        logic [3:0] fcs_ref[8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        exp_q.delete(); expl_q.delete();
        foreach (tx_q[i]) begin exp_q.push_back(tx_q[i]); expl_q.push_back(1'b0); end
        for (int k = 0; k < 8; k++) begin exp_q.push_back(fcs_ref[k]); expl_q.push_back(k == 7); end
    endtask

    task automatic test_reset();
        sel = 1'b1; in_valid = 1'b1; in_data = 4'h5; in_last = 1'b0; out_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (out_valid_o !== 1'b0) begin $display("FAIL reset_out_valid: got %b required 0", out_valid_o); n_bad++; end
        n_vec++; if (out_data_o !== 4'h0) begin $display("FAIL reset_out_data: got %h required 0", out_data_o); n_bad++; end
        n_vec++; if (out_last_o !== 1'b0) begin $display("FAIL reset_out_last: got %b required 0", out_last_o); n_bad++; end
        n_vec++; if (in_ready_o !== 1'b0) begin $display("FAIL reset_in_ready: got %b required 0", in_ready_o); n_bad++; end
        n_vec++; if ({busy_0, busy_1} !== 2'b00) begin $display("FAIL reset_busy: got %b required 00", {busy_0, busy_1}); n_bad++; end
        n_vec++; if (frame_done_o !== 1'b0) begin $display("FAIL reset_frame_done: got %b required 0", frame_done_o); n_bad++; end
        in_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (busy_o !== 1'b0) begin $display("FAIL idle_busy: got %b required 0", busy_o); n_bad++; end
    endtask

    task automatic test_basic();
        bit to;
        int d;
        sel = 1'b0;
        tx_q.delete(); tx_l.delete();
        push_bytes("123456789");
        load_frame1_expected();
        run_stream(1'b0, 1'b0, 1, 400, to);
        n_vec++; if (to !== 1'b0) begin $display("FAIL basic_timeout: got timeout=%b required 0", to); n_bad++; end
        d = first_diff();
        n_vec++; if (d !== -1) begin report_stream("basic_stream", d); n_bad++; end
        n_vec++; if (first_ov - first_acc !== 1) begin $display("FAIL basic_latency: got %0d required 1", first_ov - first_acc); n_bad++; end
    endtask

    task automatic test_pad();
        bit to;
        int d;
        sel = 1'b1;
        tx_q.delete(); tx_l.delete();
        for (int i = 0; i < 14; i++) begin tx_q.push_back(4'(i + 1)); tx_l.push_back(i == 13); end
        exp_q.delete(); expl_q.delete();
        add_expected(120, 0, 14);
        run_stream(1'b0, 1'b0, 1, 600, to);
        n_vec++; if (to !== 1'b0) begin $display("FAIL pad_timeout: got timeout=%b required 0", to); n_bad++; end
        n_vec++; if (rx_q.size() !== 128) begin $display("FAIL pad_length: got %0d required 128", rx_q.size()); n_bad++; end
        d = first_diff();
        n_vec++; if (d !== -1) begin report_stream("pad_stream", d); n_bad++; end
    endtask

    task automatic test_backpressure();
        bit to;
        int d;
        sel = 1'b0;
        tx_q.delete(); tx_l.delete();
        push_bytes("123456789");
        load_frame1_expected();
        run_stream(1'b1, 1'b1, 1, 1000, to);
        n_vec++; if (to !== 1'b0) begin $display("FAIL bp_timeout: got timeout=%b required 0", to); n_bad++; end
        d = first_diff();
        n_vec++; if (d !== -1) begin report_stream("bp_stream", d); n_bad++; end
        n_vec++; if (stall_bad !== 0) begin $display("FAIL bp_hold_stable: got %0d unstable stalls required 0", stall_bad); n_bad++; end
        n_vec++; if (stall_seen == 0) begin $display("FAIL bp_stalls: got %0d stall cycles required >0", stall_seen); n_bad++; end
    endtask

    task automatic test_back_to_back();
        bit to;
        int d, n1;
        sel = 1'b0;
        tx_q.delete(); tx_l.delete();
        push_bytes("123456789");
        n1 = tx_q.size();
        push_bytes("ABCDE");
        exp_q.delete(); expl_q.delete();
        add_expected(0, 0, n1);
        add_expected(0, n1, tx_q.size() - n1);
        run_stream(1'b0, 1'b0, 2, 800, to);
        n_vec++; if (to !== 1'b0) begin $display("FAIL b2b_timeout: got timeout=%b required 0", to); n_bad++; end
        d = first_diff();
        n_vec++; if (d !== -1) begin report_stream("b2b_stream", d); n_bad++; end
        n_vec++;
        if (gap_runs.size() < 1) begin
            $display("FAIL b2b_gap: got no in_ready recovery required 25 low cycles"); n_bad++;
        end else if (gap_runs[0] !== 25) begin
            $display("FAIL b2b_gap: got %0d low cycles required 25", gap_runs[0]); n_bad++;
        end
    endtask

    task automatic test_reset_mid_pad();
        bit to;
        int d;
        sel = 1'b1;
        tx_q.delete(); tx_l.delete();
        push_bytes("xy");
        run_stream(1'b0, 1'b0, 1, 20, to);
        n_vec++; if (to !== 1'b1) begin $display("FAIL midpad_running: got timeout=%b required 1", to); n_bad++; end
        n_vec++; if ({busy_o, out_valid_o} !== 2'b11) begin $display("FAIL midpad_active: got busy/valid=%b required 11", {busy_o, out_valid_o}); n_bad++; end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if ({busy_o, out_valid_o} !== 2'b00) begin $display("FAIL midpad_reset: got busy/valid=%b required 00", {busy_o, out_valid_o}); n_bad++; end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tx_q.delete(); tx_l.delete();
        push_bytes("ab");
        exp_q.delete(); expl_q.delete();
        add_expected(120, 0, tx_q.size());
        run_stream(1'b0, 1'b0, 1, 600, to);
        n_vec++; if (to !== 1'b0) begin $display("FAIL midpad_next_timeout: got timeout=%b required 0", to); n_bad++; end
        d = first_diff();
        n_vec++; if (d !== -1) begin report_stream("midpad_next_stream", d); n_bad++; end
    endtask

    task automatic test_one_nibble();
        bit to;
        int d;
        sel = 1'b1;
        tx_q.delete(); tx_l.delete();
        tx_q.push_back(4'hA); tx_l.push_back(1'b1);
        exp_q.delete(); expl_q.delete();
        add_expected(120, 0, 1);
        run_stream(1'b0, 1'b0, 1, 600, to);
        n_vec++; if (to !== 1'b0) begin $display("FAIL one_frame_done: got timeout=%b required 0", to); n_bad++; end
        n_vec++; if (rx_q.size() !== 128) begin $display("FAIL one_length: got %0d required 128", rx_q.size()); n_bad++; end
        d = first_diff();
        n_vec++; if (d !== -1) begin report_stream("one_stream", d); n_bad++; end
    endtask

    initial begin
        cyc_g = 0;
        test_reset();
        test_basic();
        test_pad();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_pad();
        test_one_nibble();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
